// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion paths.
// The binary-to-BCD display path also uses MAX_DIGITS.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BIN_W       = 16;
  localparam int MAX_DIGITS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double dabble: pull a digit back by 3 once it
// reaches 8. An adjusted digit is always >= 8, so the subtraction cannot wrap.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd8) ? (digit_i - 4'd3) : digit_i;

endmodule

// File: rtl/bcd_to_bin.sv
// Packed-BCD to unsigned binary converter, one reverse-double-dabble step per clock,
// behind a start/done handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; bcd_in captured on the accepting edge
// ST_SHIFT | one shift+adjust step per edge, 4*DIGITS steps in total
// ST_DONE  | result (or invalid flag) valid; done pulses for one cycle
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                          busy,
  output logic                          done,
  output logic                          invalid,
  output logic [BIN_W-1:0]              binary
);

  localparam int SREG_W = BCD_DIGIT_W * DIGITS;
  localparam int ALIGN  = BIN_W - SREG_W;
  localparam int CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SREG_W - 1);

  state_e             state_q, state_d;
  logic [SREG_W-1:0]  sreg_q, sreg_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   binary_q, binary_d;
  logic               invalid_q, invalid_d;

  logic [SREG_W-1:0]  sreg_shift;
  logic [SREG_W-1:0]  sreg_adj;
  logic [BIN_W-1:0]   acc_shift;
  logic               bad_digit;

  // {sreg, acc} shifted right as one word: sreg LSB drops into acc MSB.
  assign sreg_shift = sreg_q >> 1;
  assign acc_shift  = {sreg_q[0], acc_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (sreg_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (sreg_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    binary_d  = binary_q;
    invalid_d = invalid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d = bcd_in;
          acc_d  = '0;
          cnt_d  = '0;
          if (bad_digit) begin
            binary_d  = '0;
            invalid_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        sreg_d = sreg_adj;
        acc_d  = acc_shift;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // Converted bits sit at the top of acc; right-align them.
          binary_d  = acc_shift >> ALIGN;
          invalid_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      binary_q  <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      binary_q  <= binary_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign invalid = invalid_q;
  assign binary  = binary_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a 3-digit and a 4-digit instance share clock and reset.
// Latency is counted in rising edges after the accepting edge until done is seen high.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start3 = 1'b0;
  logic [11:0] bcd_in3 = '0;
  logic        busy3, done3, invalid3;
  logic [15:0] binary3;
  logic        start4 = 1'b0;
  logic [15:0] bcd_in4 = '0;
  logic        busy4, done4, invalid4;
  logic [15:0] binary4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd_in3),
    .busy(busy3), .done(done3), .invalid(invalid3), .binary(binary3)
  );

  bcd_to_bin #(.DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .bcd_in(bcd_in4),
    .busy(busy4), .done(done4), .invalid(invalid4), .binary(binary4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge; stops at the done cycle.
  task automatic wait_done3(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done3 && lat < 40) begin
      busy_n += int'(busy3);
      @(negedge clk);
      lat++;
    end
    busy_n += int'(busy3);
  endtask

  task automatic run3(input logic [11:0] bcd, input logic [15:0] exp_bin,
                      input logic exp_inv, input int exp_lat, input int exp_busy,
                      input string tag);
    int lat, busy_n;
    @(negedge clk);
    bcd_in3 = bcd;
    start3  = 1'b1;
    @(negedge clk);
    start3  = 1'b0;
    wait_done3(lat, busy_n);
    check({tag, "_done"}, 32'(done3), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, "_binary"}, 32'(binary3), 32'(exp_bin));
    check({tag, "_invalid"}, 32'(invalid3), 32'(exp_inv));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done3), 32'd0);
    check({tag, "_idle"}, 32'(busy3), 32'd0);
    check({tag, "_binary_hold"}, 32'(binary3), 32'(exp_bin));
  endtask

  initial begin
    int lat, busy_n, gap, extra;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_invalid", 32'(invalid3), 32'd0);
    check("rst_binary", 32'(binary3), 32'd0);
    check("rst_binary4", 32'(binary4), 32'd0);
    rst = 1'b0;

    // 999 -> 0x03E7: done 12 edges after accept, busy for 13 cycles
    run3(12'h999, 16'h03E7, 1'b0, 12, 13, "c999");
    run3(12'h255, 16'h00FF, 1'b0, 12, 13, "c255");
    run3(12'h000, 16'h0000, 1'b0, 12, 13, "c000");

    // Tens digit 0xA: done in the cycle directly following the accepting edge
    run3(12'h1A3, 16'h0000, 1'b1, 0, 1, "c1A3");
    run3(12'h042, 16'h002A, 1'b0, 12, 13, "c042");

    // Start held high: next accept on first IDLE edge after DONE, 14 cycles apart
    @(negedge clk);
    bcd_in3 = 12'h255;
    start3  = 1'b1;
    @(negedge clk);
    wait_done3(lat, busy_n);
    check("b2b_first_lat", 32'(lat), 32'd12);
    check("b2b_first_binary", 32'(binary3), 32'h00FF);
    bcd_in3 = 12'h000;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done3 && gap < 40);
    check("b2b_gap", 32'(gap), 32'd14);
    check("b2b_second_binary", 32'(binary3), 32'h0000);
    start3 = 1'b0;
    @(negedge clk);

    // Start pulse while busy is ignored; exactly one done
    @(negedge clk);
    bcd_in3 = 12'h999;
    start3  = 1'b1;
    @(negedge clk);
    start3  = 1'b0;
    lat = 0;
    while (!done3 && lat < 40) begin
      start3 = (lat == 5);
      if (lat == 5) bcd_in3 = 12'h111;
      @(negedge clk);
      lat++;
    end
    start3 = 1'b0;
    check("ign_lat", 32'(lat), 32'd12);
    check("ign_binary", 32'(binary3), 32'h03E7);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done3);
    end
    check("ign_extra_done", 32'(extra), 32'd0);
    check("ign_binary_hold", 32'(binary3), 32'h03E7);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    bcd_in3 = 12'h999;
    start3  = 1'b1;
    @(negedge clk);
    start3  = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy3), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy3), 32'd0);
    check("arst_done", 32'(done3), 32'd0);
    check("arst_invalid", 32'(invalid3), 32'd0);
    check("arst_binary", 32'(binary3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(done3);
    end
    check("arst_no_done", 32'(extra), 32'd0);
    check("arst_idle", 32'(busy3), 32'd0);
    run3(12'h500, 16'h01F4, 1'b0, 12, 13, "c500");

    // Four-digit instance: 9999 -> 0x270F after 16 steps
    @(negedge clk);
    bcd_in4 = 16'h9999;
    start4  = 1'b1;
    @(negedge clk);
    start4  = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("d4_done", 32'(done4), 32'd1);
    check("d4_lat", 32'(lat), 32'd16);
    check("d4_binary", 32'(binary4), 32'h270F);
    check("d4_invalid", 32'(invalid4), 32'd0);
    @(negedge clk);
    check("d4_done_pulse", 32'(done4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
